// File: rtl/ufp_pkg.sv
// ufp_pkg: shared FSM state type and iteration-count helper for the fixed-point square root
package ufp_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_e;
  function automatic int sqrt_iters(int iw, int qw);
    int rw;
    rw = iw + 2 * qw;
    return (rw + rw % 2) / 2;
  endfunction
endpackage

// File: rtl/ufp_if.sv
// ufp_if: unsigned fixed-point IW.QW value bus
interface ufp_if #(parameter int IW = 8, parameter int QW = 8);
  logic [IW+QW-1:0] val;
  modport in(input val);
  modport out(output val);
endinterface

// File: rtl/ufp_sqrt_step.sv
// ufp_sqrt_step: one combinational restoring square-root iteration
module ufp_sqrt_step #(parameter int N = 12) (
  input  logic [N+1:0] rem,
  input  logic [N-1:0] root,
  input  logic [1:0]   b,
  output logic [N+1:0] rem_n,
  output logic [N-1:0] root_n
);
  logic [N+3:0] rs, tr, df;
  logic ge;
  assign rs = {rem, b};
  assign tr = {2'b00, root, 2'b01};
  assign df = rs - tr;
  assign ge = rs >= tr;
  assign rem_n = ge ? df[N+1:0] : rs[N+1:0];
  assign root_n = {root[N-2:0], ge};
endmodule

// File: rtl/ufp_sqrt_seq.sv
// ufp_sqrt_seq: iterative floor(sqrt) of an IW.QW operand, one result bit per clock
module ufp_sqrt_seq import ufp_pkg::*; #(
  parameter int IW = 8,
  parameter int QW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  ufp_if.in    op,
  output logic out_valid,
  input  logic out_ready,
  ufp_if.out   res,
  output logic res_exact
);
  localparam int WL = IW + QW;
  localparam int N = sqrt_iters(IW, QW);
  localparam int RW = 2 * N;
  localparam int CW = $clog2(N + 1);
  if ($bits(op.val) != WL || $bits(res.val) != WL) begin : g_width_chk
    $error("ufp_sqrt_seq: bound interface IW/QW do not match module parameters");
  end
  sqrt_state_e state;
  logic [RW-1:0] rad;
  logic [N+1:0] rem, rem_n;
  logic [N-1:0] root, root_n;
  logic [CW-1:0] cnt;
  ufp_sqrt_step #(.N(N)) u_step (
    .rem(rem), .root(root), .b(rad[RW-1:RW-2]), .rem_n(rem_n), .root_n(root_n)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign res.val = WL'(root);
  assign res_exact = state == DONE && rem == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rad <= '0;
      rem <= '0;
      root <= '0;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      rad <= RW'({op.val, {QW{1'b0}}});
      rem <= '0;
      root <= '0;
      cnt <= CW'(N - 1);
      state <= CALC;
    end else if (state == CALC) begin
      rad <= rad << 2;
      rem <= rem_n;
      root <= root_n;
      cnt <= cnt == '0 ? cnt : cnt - 1'b1;
      state <= cnt == '0 ? DONE : CALC;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_ufp_sqrt_seq.sv
// tb_ufp_sqrt_seq: randomized and directed checks of ufp_sqrt_seq against an integer sqrt model
module tb_ufp_sqrt_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, res_exact;
  int checks = 0, errors = 0;
  ufp_if #(.IW(8), .QW(8)) op_if ();
  ufp_if #(.IW(8), .QW(8)) res_if ();
  ufp_sqrt_seq #(.IW(8), .QW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op_if),
    .out_valid(out_valid), .out_ready(out_ready), .res(res_if), .res_exact(res_exact)
  );
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_root(logic [15:0] v);
    longint x, r, t;
    x = longint'(v) << 8;
    r = 0;
    for (int b = 11; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return 16'(r);
  endfunction

  function automatic logic ref_exact(logic [15:0] v);
    longint r;
    r = longint'(ref_root(v));
    return r * r == (longint'(v) << 8);
  endfunction

  // drives one operand with out_ready held high; lat counts edges from accept to out_valid, -1 on timeout
  task automatic do_op(input logic [15:0] v, output logic [15:0] r, output logic e, output int lat);
    @(negedge clk);
    in_valid = 1; op_if.val = v; out_ready = 1; lat = -1; r = 'x; e = 'x;
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    @(negedge clk);
    in_valid = 0;
    for (int i = 1; i < 40; i++) begin
      if (out_valid) begin lat = i; r = res_if.val; e = res_exact; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 0; out_ready = 0; op_if.val = 0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (res_if.val !== 16'h0) begin errors++; $display("FAIL reset_res got %h want 0000", res_if.val); end
    checks++; if (res_exact !== 1'b0) begin errors++; $display("FAIL reset_exact got %b want 0", res_exact); end
    rst = 0;
  endtask

  task automatic test_basic;
    logic [15:0] ops [5] = '{16'h0400, 16'h0200, 16'h0000, 16'hFFFF, 16'h0100};
    logic [15:0] want [5] = '{16'h0200, 16'h016A, 16'h0000, 16'h0FFF, 16'h0100};
    logic we [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] r;
    logic e;
    int lat;
    for (int k = 0; k < 5; k++) begin
      do_op(ops[k], r, e, lat);
      checks++; if (lat !== 13) begin errors++; $display("FAIL latency op=%h got %0d want 13", ops[k], lat); end
      checks++; if (r !== want[k]) begin errors++; $display("FAIL res op=%h got %h want %h", ops[k], r, want[k]); end
      checks++; if (e !== we[k]) begin errors++; $display("FAIL exact op=%h got %b want %b", ops[k], e, we[k]); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] held;
    int seen = 0;
    @(negedge clk);
    out_ready = 0; in_valid = 1; op_if.val = 16'h0900;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    held = res_if.val;
    checks++; if (held !== 16'h0300) begin errors++; $display("FAIL bp_res got %h want 0300", held); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; op_if.val = 16'h0100;
      @(negedge clk);
      if (out_valid === 1'b1 && res_if.val === 16'h0300 && in_ready === 1'b0) seen++;
    end
    checks++; if (seen !== 5) begin errors++; $display("FAIL bp_hold stable cycles got %0d want 5", seen); end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready in_ready got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] r;
    logic e;
    int lat, pulses = 0;
    @(negedge clk);
    in_valid = 1; op_if.val = 16'h0900; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst out_valid got %b want 0", out_valid); end
    checks++; if (res_if.val !== 16'h0) begin errors++; $display("FAIL mid_rst res got %h want 0000", res_if.val); end
    repeat (20) begin @(negedge clk); if (out_valid) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_rst spurious out_valid got %0d want 0", pulses); end
    do_op(16'h0900, r, e, lat);
    checks++; if (r !== 16'h0300) begin errors++; $display("FAIL after_rst res got %h want 0300", r); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL after_rst exact got %b want 1", e); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] q [$];
    logic [15:0] v, exp_v;
    int sent = 0, got = 0, extra = 0;
    int n = 150;
    for (int cyc = 0; cyc < 20000 && got < n; cyc++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0: v = 16'hFFFF;
        1: v = 16'h0000;
        2: v = 16'(($urandom_range(0, 255)) ** 2 >> 8);
        default: v = 16'($urandom);
      endcase
      in_valid = sent < n && $urandom_range(0, 2) != 0;
      op_if.val = v;
      if (in_valid && in_ready) begin q.push_back(v); sent++; end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b unexpected result got %h want none", res_if.val); end
        else begin
          exp_v = q.pop_front();
          if (res_if.val !== ref_root(exp_v) || res_exact !== ref_exact(exp_v)) begin
            errors++;
            $display("FAIL b2b op=%h got %h/%b want %h/%b", exp_v, res_if.val, res_exact, ref_root(exp_v), ref_exact(exp_v));
          end
        end
      end
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    repeat (20) begin @(negedge clk); if (out_valid) extra++; end
    checks++; if (got !== n) begin errors++; $display("FAIL b2b result count got %0d want %0d", got, n); end
    checks++; if (extra !== 0 || q.size() != 0) begin errors++; $display("FAIL b2b leftovers got %0d/%0d want 0/0", extra, q.size()); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
